// File: rtl/module_gray_scan_display.sv
// -----------------------------------------------------------------------------
// module_gray_scan_display
//
// Accepts a Gray-coded word over a valid/ready handshake and converts it to
// binary one bit per cycle, MSB first. The last completed result is held on
// binary_out and shown as hex across NUM_DIGITS time-multiplexed 7-segment
// digits.
//
// Optional build macro:
//   GRAY_LEADING_ZERO_BLANK_EN  blank digits above the most significant
//                               non-zero nibble (digit 0 always lit).
//
// Ports:
//   clk           in   system clock, rising edge
//   rst           in   synchronous active-high reset
//   gray_valid    in   gray_code is valid
//   gray_code     in   Gray-coded input word [GRAY_WIDTH]
//   gray_ready    out  block can accept a word (combinational)
//   binary_out    out  last completed binary result (registered)
//   binary_valid  out  one-cycle pulse when binary_out updates
//   seg           out  segments {g,f,e,d,c,b,a}, active-low
//   anode         out  digit enables, one-hot active-low [NUM_DIGITS]
// -----------------------------------------------------------------------------
module module_gray_scan_display #(
  parameter int GRAY_WIDTH  = 8,
  parameter int NUM_DIGITS  = 2,
  parameter int REFRESH_DIV = 50000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  gray_valid,
  input  logic [GRAY_WIDTH-1:0] gray_code,
  output logic                  gray_ready,
  output logic [GRAY_WIDTH-1:0] binary_out,
  output logic                  binary_valid,
  output logic [6:0]            seg,
  output logic [NUM_DIGITS-1:0] anode
);

  localparam int CNT_W  = $clog2(GRAY_WIDTH);
  localparam int SCAN_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int DIG_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int PAD_W  = 4 * NUM_DIGITS;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CONV,
    S_DONE
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [GRAY_WIDTH-1:0] r_gray;
  logic [GRAY_WIDTH-1:0] r_bin;
  logic [CNT_W-1:0]      r_bit_cnt;
  logic [GRAY_WIDTH-1:0] r_binary_out;
  logic                  r_binary_valid;
  logic                  w_accept;
  logic                  w_last;
  logic                  w_bin_bit;

  assign gray_ready   = (r_state == S_IDLE) & ~rst;
  assign w_accept     = gray_valid & gray_ready;
  assign w_last       = (r_state == S_CONV) && (r_bit_cnt == CNT_W'(GRAY_WIDTH - 1));
  // r_bin[0] is the previously produced binary bit b[i+1]; it is cleared on
  // accept so the first step yields b[MSB] = g[MSB].
  assign w_bin_bit    = r_bin[0] ^ r_gray[GRAY_WIDTH-1];
  assign binary_out   = r_binary_out;
  assign binary_valid = r_binary_valid;

  // NOTE: state and data registers use non-blocking assignments so every
  // flop samples pre-edge values, regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  // NOTE: the next-state value is defaulted first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      S_IDLE:  if (w_accept) w_state_next = S_CONV;
      S_CONV:  if (w_last)   w_state_next = S_DONE;
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Conversion datapath: shift the Gray word out MSB first and shift the
  // binary result in LSB side; the final edge loads binary_out directly.
  // NOTE: the working shift registers are reset along with everything else;
  // they are small flop vectors, not a memory, so reset costs nothing extra.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_gray         <= '0;
      r_bin          <= '0;
      r_bit_cnt      <= '0;
      r_binary_out   <= '0;
      r_binary_valid <= 1'b0;
    end else begin
      r_binary_valid <= w_last;
      if (w_accept) begin
        r_gray    <= gray_code;
        r_bin     <= '0;
        r_bit_cnt <= '0;
      end else if (r_state == S_CONV) begin
        r_gray    <= r_gray << 1;
        r_bin     <= {r_bin[GRAY_WIDTH-2:0], w_bin_bit};
        r_bit_cnt <= r_bit_cnt + 1'b1;
        if (w_last) r_binary_out <= {r_bin[GRAY_WIDTH-2:0], w_bin_bit};
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Display scan
  // ---------------------------------------------------------------------------
  function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
    logic [6:0] g;
    unique case (nib)
      4'h0: g = 7'b1000000;
      4'h1: g = 7'b1111001;
      4'h2: g = 7'b0100100;
      4'h3: g = 7'b0110000;
      4'h4: g = 7'b0011001;
      4'h5: g = 7'b0010010;
      4'h6: g = 7'b0000010;
      4'h7: g = 7'b1111000;
      4'h8: g = 7'b0000000;
      4'h9: g = 7'b0010000;
      4'hA: g = 7'b0001000;
      4'hB: g = 7'b0000011;
      4'hC: g = 7'b1000110;
      4'hD: g = 7'b0100001;
      4'hE: g = 7'b0000110;
      default: g = 7'b0001110;
    endcase
    return g;
  endfunction

  logic [SCAN_W-1:0]     r_scan_cnt;
  logic [DIG_W-1:0]      r_digit;
  logic [6:0]            r_seg;
  logic [NUM_DIGITS-1:0] r_anode;
  logic [DIG_W-1:0]      w_digit_next;
  logic [PAD_W-1:0]      w_padded;
  logic [3:0]            w_nibble;
  logic [6:0]            w_seg_next;
  logic [NUM_DIGITS-1:0] w_anode_next;
  logic                  w_scan_wrap;

  assign w_scan_wrap = (r_scan_cnt == SCAN_W'(REFRESH_DIV - 1));

  // seg/anode are computed from the digit index the scan is moving to, so
  // both registers switch on the same edge as the index itself.
  always_comb begin
    w_digit_next = r_digit;
    if (w_scan_wrap) begin
      if (r_digit == DIG_W'(NUM_DIGITS - 1)) w_digit_next = '0;
      else                                   w_digit_next = r_digit + 1'b1;
    end

    w_padded                 = '0;
    w_padded[GRAY_WIDTH-1:0] = r_binary_out;
    w_nibble                 = w_padded[{w_digit_next, 2'b00} +: 4];
    w_seg_next               = hex_glyph(w_nibble);
`ifdef GRAY_LEADING_ZERO_BLANK_EN
    // Everything from this digit upward is zero: it is a leading zero.
    if ((w_digit_next != '0) && ((w_padded >> {w_digit_next, 2'b00}) == '0))
      w_seg_next = 7'b1111111;
`endif

    w_anode_next               = '1;
    w_anode_next[w_digit_next] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_scan_cnt <= '0;
      r_digit    <= '0;
      r_seg      <= 7'b1000000;
      r_anode    <= {{(NUM_DIGITS-1){1'b1}}, 1'b0};
    end else begin
      r_scan_cnt <= w_scan_wrap ? '0 : r_scan_cnt + 1'b1;
      r_digit    <= w_digit_next;
      r_seg      <= w_seg_next;
      r_anode    <= w_anode_next;
    end
  end

  assign seg   = r_seg;
  assign anode = r_anode;

endmodule
